// File: rtl/core_types_pkg.sv
// core_types_pkg: shared pipeline types for the hazard/forwarding control.
//   hz_state_t  - hazard controller states
//   fwd_sel_t   - ALU operand source select
//   DEC_out_t   - ID/EX register fields consumed by hazard logic
//   reg_match() - "destination writes a nonzero register equal to src" test
package core_types_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned WAIT_W = 8;
   localparam int unsigned CNT_W  = 32;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_REDIRECT = 2'd1,
      HZ_MEM_WAIT = 2'd2
   } hz_state_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EXM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_t;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] addr1;
      logic [REG_W-1:0] addr2;
      logic             Rmem;
   } DEC_out_t;

   // x0 is hardwired zero, so it never matches as a dependency.
   function automatic logic reg_match(input logic             wen,
                                      input logic [REG_W-1:0] dst,
                                      input logic [REG_W-1:0] src);
      return wen && (dst != '0) && (dst == src);
   endfunction

endpackage

// File: rtl/hazard_fwd.sv
// hazard_fwd: operand forwarding select for one ALU source register.
// Ports:
//   i_src_addr          - source register of the instruction in EX
//   i_exm_rd/i_exm_Wreg - EX/MEM destination and write enable
//   i_wb_rd/i_wb_Wreg   - MEM/WB destination and write enable
//   o_fwd_sel           - FWD_EXM / FWD_WB / FWD_RF (combinational)
module hazard_fwd
   import core_types_pkg::*;
(
   input  logic [REG_W-1:0] i_src_addr,
   input  logic [REG_W-1:0] i_exm_rd,
   input  logic             i_exm_Wreg,
   input  logic [REG_W-1:0] i_wb_rd,
   input  logic             i_wb_Wreg,
   output fwd_sel_t         o_fwd_sel
);

   // Younger result (EX/MEM) takes precedence over MEM/WB.
   always_comb begin
      o_fwd_sel = FWD_RF;
      if (reg_match(i_exm_Wreg, i_exm_rd, i_src_addr)) begin
         o_fwd_sel = FWD_EXM;
      end else if (reg_match(i_wb_Wreg, i_wb_rd, i_src_addr)) begin
         o_fwd_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush control, operand forwarding and
// memory-wait timeout detection.
// Ports:
//   Clock, nReset                 - core clock, async active-low reset
//   DEC_out                       - ID/EX contents (rd, addr1, addr2, Rmem)
//   id_addr1/2, id_use1/2         - decode-stage source registers and usage
//   branch_taken                  - taken branch/jump resolved in EX
//   mem_busy                      - data memory not ready
//   exm_rd/Wreg, wb_rd/Wreg       - later-stage destinations
//   stall_pc/ifid/dec             - hold PC, IF/ID, ID/EX (combinational)
//   flush_ifid, flush             - bubble IF/ID, ID/EX (combinational)
//   fwd1_sel, fwd2_sel            - ALU operand sources (combinational)
//   mem_timeout                   - sticky memory-wait timeout flag
//   stall_cnt, flush_cnt          - performance counters
// Build option: HAZARD_PERF_EN enables the performance counters; without
// it both counters read 0.
module hazard_unit
   import core_types_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             Clock,
   input  logic             nReset,
   input  DEC_out_t         DEC_out,
   input  logic [REG_W-1:0] id_addr1,
   input  logic [REG_W-1:0] id_addr2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic             branch_taken,
   input  logic             mem_busy,
   input  logic [REG_W-1:0] exm_rd,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             exm_Wreg,
   input  logic             wb_Wreg,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             stall_dec,
   output logic             flush_ifid,
   output logic             flush,
   output fwd_sel_t         fwd1_sel,
   output fwd_sel_t         fwd2_sel,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   hz_state_t         r_state;
   hz_state_t         w_next_state;
   logic              r_pending;
   logic              w_pending_next;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_next;
   logic              r_timeout;
   logic              w_timeout_hit;
   logic              w_load_use;

   // Load in EX whose destination the decode instruction reads.
   assign w_load_use = DEC_out.Rmem &&
                       (reg_match(id_use1, DEC_out.rd, id_addr1) ||
                        reg_match(id_use2, DEC_out.rd, id_addr2));

   // Next state and stall/flush outputs; priority mem_busy > branch > load-use.
   always_comb begin
      w_next_state   = r_state;
      w_pending_next = r_pending;
      stall_pc       = 1'b0;
      stall_ifid     = 1'b0;
      stall_dec      = 1'b0;
      flush_ifid     = 1'b0;
      flush          = 1'b0;

      if (mem_busy) begin
         stall_pc     = 1'b1;
         stall_ifid   = 1'b1;
         stall_dec    = 1'b1;
         w_next_state = HZ_MEM_WAIT;
         // A branch masked by the memory hold is remembered, not dropped.
         if (branch_taken) begin
            w_pending_next = 1'b1;
         end
      end else begin
         case (r_state)
            HZ_REDIRECT: begin
               // Synchronous instruction memory: one more wrong-path fetch.
               flush_ifid   = 1'b1;
               w_next_state = HZ_RUN;
            end
            HZ_RUN, HZ_MEM_WAIT: begin
               w_next_state = HZ_RUN;
               if (branch_taken || r_pending) begin
                  flush_ifid     = 1'b1;
                  flush          = 1'b1;
                  w_pending_next = 1'b0;
                  w_next_state   = HZ_REDIRECT;
               end else if (w_load_use) begin
                  stall_pc   = 1'b1;
                  stall_ifid = 1'b1;
                  flush      = 1'b1;
               end
            end
            default: begin
               w_next_state = HZ_RUN;
            end
         endcase
      end

      if (!nReset) begin
         stall_pc   = 1'b0;
         stall_ifid = 1'b0;
         stall_dec  = 1'b0;
         flush_ifid = 1'b0;
         flush      = 1'b0;
      end
   end

   // Busy-cycle counter: restarts at 1 on the first busy cycle of a wait.
   always_comb begin
      w_wait_next = r_wait_cnt;
      if (mem_busy) begin
         if (r_state != HZ_MEM_WAIT) begin
            w_wait_next = WAIT_W'(1);
         end else if (r_wait_cnt != '1) begin
            w_wait_next = r_wait_cnt + WAIT_W'(1);
         end
      end
      w_timeout_hit = mem_busy && (w_wait_next >= WAIT_LIMIT);
   end

   // State register and sticky timeout.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state    <= HZ_RUN;
         r_pending  <= 1'b0;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_pending  <= w_pending_next;
         r_wait_cnt <= w_wait_next;
         r_timeout  <= r_timeout | w_timeout_hit;
      end
   end

   assign mem_timeout = r_timeout;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Free-running event counters, wrapping naturally.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall_pc) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (flush) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

   hazard_fwd u_fwd1 (
      .i_src_addr (DEC_out.addr1),
      .i_exm_rd   (exm_rd),
      .i_exm_Wreg (exm_Wreg),
      .i_wb_rd    (wb_rd),
      .i_wb_Wreg  (wb_Wreg),
      .o_fwd_sel  (fwd1_sel)
   );

   hazard_fwd u_fwd2 (
      .i_src_addr (DEC_out.addr2),
      .i_exm_rd   (exm_rd),
      .i_exm_Wreg (exm_Wreg),
      .i_wb_rd    (wb_rd),
      .i_wb_Wreg  (wb_Wreg),
      .o_fwd_sel  (fwd2_sel)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a
// behavioural model of the hazard rules.
module tb_hazard_unit;
   import core_types_pkg::*;

   localparam int TB_TIMEOUT = 3;

   logic        Clock;
   logic        nReset;
   DEC_out_t    DEC_out;
   logic [4:0]  id_addr1, id_addr2;
   logic        id_use1, id_use2;
   logic        branch_taken, mem_busy;
   logic [4:0]  exm_rd, wb_rd;
   logic        exm_Wreg, wb_Wreg;
   logic        stall_pc, stall_ifid, stall_dec, flush_ifid, flush;
   fwd_sel_t    fwd1_sel, fwd2_sel;
   logic        mem_timeout;
   logic [31:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;
   bit run_chk = 1'b1;
   int busy_left = 0;

   hazard_unit #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
      .Clock        (Clock),
      .nReset       (nReset),
      .DEC_out      (DEC_out),
      .id_addr1     (id_addr1),
      .id_addr2     (id_addr2),
      .id_use1      (id_use1),
      .id_use2      (id_use2),
      .branch_taken (branch_taken),
      .mem_busy     (mem_busy),
      .exm_rd       (exm_rd),
      .wb_rd        (wb_rd),
      .exm_Wreg     (exm_Wreg),
      .wb_Wreg      (wb_Wreg),
      .stall_pc     (stall_pc),
      .stall_ifid   (stall_ifid),
      .stall_dec    (stall_dec),
      .flush_ifid   (flush_ifid),
      .flush        (flush),
      .fwd1_sel     (fwd1_sel),
      .fwd2_sel     (fwd2_sel),
      .mem_timeout  (mem_timeout),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------- behavioural model ----------------
   bit          m_redir;   // previous cycle launched a redirect (no busy)
   bit          m_pend;    // branch hidden behind a memory hold
   int          m_run;     // length of the current run of busy cycles
   bit          m_tout;
   int unsigned m_scnt, m_fcnt;

   function automatic void exp_ctrl(output bit s_pc, output bit s_ifid,
                                    output bit s_dec, output bit f_ifid,
                                    output bit f);
      bit lu;
      s_pc = 0; s_ifid = 0; s_dec = 0; f_ifid = 0; f = 0;
      lu = DEC_out.Rmem && (DEC_out.rd != 5'd0) &&
           ((id_use1 && DEC_out.rd == id_addr1) ||
            (id_use2 && DEC_out.rd == id_addr2));
      if (nReset) begin
         if (mem_busy) begin
            s_pc = 1; s_ifid = 1; s_dec = 1;
         end else if (m_redir) begin
            f_ifid = 1;
         end else if (branch_taken || m_pend) begin
            f = 1; f_ifid = 1;
         end else if (lu) begin
            s_pc = 1; s_ifid = 1; f = 1;
         end
      end
   endfunction

   function automatic int exp_fwd(input logic [4:0] a);
      if (a == 5'd0)                 return int'(FWD_RF);
      if (exm_Wreg && exm_rd == a)   return int'(FWD_EXM);
      if (wb_Wreg && wb_rd == a)     return int'(FWD_WB);
      return int'(FWD_RF);
   endfunction

   always @(posedge Clock) begin : model_update
      bit s_pc, s_ifid, s_dec, f_ifid, f, redir_n;
      if (!nReset) begin
         m_redir = 0; m_pend = 0; m_run = 0; m_tout = 0;
         m_scnt = 0; m_fcnt = 0;
      end else begin
         exp_ctrl(s_pc, s_ifid, s_dec, f_ifid, f);
         if (s_pc) m_scnt++;
         if (f)    m_fcnt++;
         m_run = mem_busy ? m_run + 1 : 0;
         if (mem_busy && m_run >= TB_TIMEOUT) m_tout = 1;
         redir_n = !mem_busy && !m_redir && (branch_taken || m_pend);
         m_pend  = mem_busy && (m_pend || branch_taken);
         m_redir = redir_n;
      end
   end

   // ---------------- comparison helpers ----------------
   task automatic chk_b(input string name, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_w(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge Clock) begin : compare
      bit s_pc, s_ifid, s_dec, f_ifid, f;
      if (run_chk) begin
         exp_ctrl(s_pc, s_ifid, s_dec, f_ifid, f);
         chk_b("stall_pc",   stall_pc,   s_pc);
         chk_b("stall_ifid", stall_ifid, s_ifid);
         chk_b("stall_dec",  stall_dec,  s_dec);
         chk_b("flush_ifid", flush_ifid, f_ifid);
         chk_b("flush",      flush,      f);
         chk_w("fwd1_sel", 32'(fwd1_sel), 32'(exp_fwd(DEC_out.addr1)));
         chk_w("fwd2_sel", 32'(fwd2_sel), 32'(exp_fwd(DEC_out.addr2)));
         chk_b("mem_timeout", mem_timeout, nReset ? m_tout : 1'b0);
`ifdef HAZARD_PERF_EN
         chk_w("stall_cnt", stall_cnt, nReset ? m_scnt : 32'd0);
         chk_w("flush_cnt", flush_cnt, nReset ? m_fcnt : 32'd0);
`else
         chk_w("stall_cnt", stall_cnt, 32'd0);
         chk_w("flush_cnt", flush_cnt, 32'd0);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      DEC_out      = '0;
      id_addr1     = 5'd0; id_addr2 = 5'd0;
      id_use1      = 1'b0; id_use2  = 1'b0;
      branch_taken = 1'b0; mem_busy = 1'b0;
      exm_rd       = 5'd0; wb_rd    = 5'd0;
      exm_Wreg     = 1'b0; wb_Wreg  = 1'b0;
   endtask

   task automatic nxt();
      @(posedge Clock);
      #1;
   endtask

   task automatic at_neg();
      @(negedge Clock);
   endtask

   task automatic reset_pulse();
      idle();
      nReset = 1'b0;
      nxt();
      nReset = 1'b1;
   endtask

   task automatic rand_inputs();
      DEC_out.rd    = 5'($urandom_range(0, 7));
      DEC_out.addr1 = 5'($urandom_range(0, 7));
      DEC_out.addr2 = 5'($urandom_range(0, 7));
      DEC_out.Rmem  = ($urandom_range(0, 3) == 0);
      id_addr1      = 5'($urandom_range(0, 7));
      id_addr2      = 5'($urandom_range(0, 7));
      id_use1       = ($urandom_range(0, 1) == 1);
      id_use2       = ($urandom_range(0, 1) == 1);
      branch_taken  = ($urandom_range(0, 9) == 0);
      exm_rd        = 5'($urandom_range(0, 7));
      wb_rd         = 5'($urandom_range(0, 7));
      exm_Wreg      = ($urandom_range(0, 1) == 1);
      wb_Wreg       = ($urandom_range(0, 1) == 1);
      if (busy_left > 0) begin
         mem_busy = 1'b1;
         busy_left--;
      end else if ($urandom_range(0, 11) == 0) begin
         mem_busy  = 1'b1;
         busy_left = int'($urandom_range(0, 5));
      end else begin
         mem_busy = 1'b0;
      end
      nReset = ($urandom_range(0, 149) != 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      idle();
      nReset   = 1'b0;
      mem_busy = 1'b1;
      at_neg();
      chk_b("rst_stall_pc", stall_pc, 1'b0);
      chk_b("rst_stall_dec", stall_dec, 1'b0);
      chk_b("rst_timeout", mem_timeout, 1'b0);
      chk_w("rst_stall_cnt", stall_cnt, 32'd0);
      nxt();
      mem_busy = 1'b0;
      nxt();
      nReset = 1'b1;

      // Load-use: one stall cycle, then the bubble clears it.
      DEC_out.Rmem = 1'b1; DEC_out.rd = 5'd5;
      id_addr1 = 5'd5; id_use1 = 1'b1;
      at_neg();
      chk_b("lu_stall_pc", stall_pc, 1'b1);
      chk_b("lu_stall_ifid", stall_ifid, 1'b1);
      chk_b("lu_flush", flush, 1'b1);
      chk_b("lu_stall_dec", stall_dec, 1'b0);
      nxt();
      DEC_out = '0;
      at_neg();
      chk_b("lu_after_stall", stall_pc, 1'b0);
      chk_b("lu_after_flush", flush, 1'b0);
      nxt();

      // Load-use on x0 must not stall.
      DEC_out.Rmem = 1'b1; DEC_out.rd = 5'd0;
      id_addr1 = 5'd0; id_use1 = 1'b1;
      at_neg();
      chk_b("lu_x0", stall_pc, 1'b0);
      nxt();
      idle();

      // Branch pulse: flush cycle N, flush_ifid N and N+1.
      branch_taken = 1'b1;
      at_neg();
      chk_b("br_flush_n", flush, 1'b1);
      chk_b("br_fifid_n", flush_ifid, 1'b1);
      nxt();
      branch_taken = 1'b0;
      at_neg();
      chk_b("br_flush_n1", flush, 1'b0);
      chk_b("br_fifid_n1", flush_ifid, 1'b1);
      nxt();
      at_neg();
      chk_b("br_fifid_n2", flush_ifid, 1'b0);
      nxt();

      // Branch hidden in a 4-cycle memory hold.
      for (int k = 1; k <= 4; k++) begin
         mem_busy     = 1'b1;
         branch_taken = (k == 2);
         at_neg();
         chk_b("mw_stall_pc", stall_pc, 1'b1);
         chk_b("mw_stall_dec", stall_dec, 1'b1);
         chk_b("mw_flush", flush, 1'b0);
         nxt();
      end
      idle();
      at_neg();
      chk_b("mw_exit_flush", flush, 1'b1);
      chk_b("mw_exit_fifid", flush_ifid, 1'b1);
      chk_b("mw_exit_stall", stall_pc, 1'b0);
      nxt();
      at_neg();
      chk_b("mw_exit_fifid2", flush_ifid, 1'b1);
      chk_b("mw_exit_flush2", flush, 1'b0);
      nxt();

      // Forwarding priority and x0.
      exm_rd = 5'd7; wb_rd = 5'd7; exm_Wreg = 1'b1; wb_Wreg = 1'b1;
      DEC_out.addr1 = 5'd7;
      at_neg();
      chk_w("fwd_exm_wins", 32'(fwd1_sel), 32'(FWD_EXM));
      exm_Wreg = 1'b0;
      #1;
      chk_w("fwd_wb", 32'(fwd1_sel), 32'(FWD_WB));
      wb_rd = 5'd0; DEC_out.addr2 = 5'd0;
      #1;
      chk_w("fwd_x0", 32'(fwd2_sel), 32'(FWD_RF));
      nxt();
      idle();

      // Timeout after the 3rd busy cycle, sticky, cleared by reset.
      reset_pulse();
      mem_busy = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         at_neg();
         chk_b("tout_rise", mem_timeout, (k >= 4));
         nxt();
      end
      mem_busy = 1'b0;
      at_neg();
      chk_b("tout_sticky", mem_timeout, 1'b1);
      chk_b("tout_nostall", stall_pc, 1'b0);
      #1;
      nReset = 1'b0;
      #1;
      chk_b("tout_cleared", mem_timeout, 1'b0);
      mem_busy = 1'b1;
      #1;
      chk_b("rst_gates_stall", stall_ifid, 1'b0);
      nxt();
      mem_busy = 1'b0;
      nReset   = 1'b1;

      // Reset during a memory wait drops the pending branch.
      mem_busy = 1'b1; branch_taken = 1'b1;
      nxt();
      branch_taken = 1'b0;
      at_neg();
      #1;
      nReset = 1'b0; mem_busy = 1'b0;
      nxt();
      nReset = 1'b1;
      at_neg();
      chk_b("rst_pend_flush", flush, 1'b0);
      chk_b("rst_pend_fifid", flush_ifid, 1'b0);
      nxt();

      // Reset during a redirect drops the second IF/ID flush.
      branch_taken = 1'b1;
      nxt();
      branch_taken = 1'b0;
      nReset = 1'b0;
      nxt();
      nReset = 1'b1;
      at_neg();
      chk_b("rst_redir_fifid", flush_ifid, 1'b0);
      nxt();

      // Performance counters: 3 load-use stalls + 2 branches.
      reset_pulse();
      for (int k = 0; k < 3; k++) begin
         DEC_out.Rmem = 1'b1; DEC_out.rd = 5'd9;
         id_addr2 = 5'd9; id_use2 = 1'b1;
         nxt();
         idle();
         nxt();
      end
      for (int k = 0; k < 2; k++) begin
         branch_taken = 1'b1;
         nxt();
         idle();
         nxt();
         nxt();
      end
      at_neg();
`ifdef HAZARD_PERF_EN
      chk_w("perf_stall", stall_cnt, 32'd3);
      chk_w("perf_flush", flush_cnt, 32'd5);
`else
      chk_w("perf_stall", stall_cnt, 32'd0);
      chk_w("perf_flush", flush_cnt, 32'd0);
`endif
      nxt();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         nxt();
      end

      idle();
      nReset = 1'b1;
      at_neg();
      run_chk = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: mem_busy cycles before timeout error; range 1..255.
REQ-002 Clock  in  1  core clock; all state updates on rising edge.
REQ-003 nReset  in  1  asynchronous active-low reset.
REQ-004 DEC_out  in  DEC_out_t  ID/EX register contents; uses rd, addr1, addr2, Rmem.
REQ-005 id_addr1, id_addr2  in  5 each  source registers of the instruction now in decode.
REQ-006 id_use1, id_use2  in  1 each  decode instruction reads rs1 / rs2.
REQ-007 branch_taken  in  1  EXE resolved a taken branch or jump this cycle.
REQ-008 mem_busy  in  1  data memory not ready; pipeline must hold.
REQ-009 exm_rd, wb_rd  in  5 each  destinations in EX/MEM and MEM/WB.
REQ-010 exm_Wreg, wb_Wreg  in  1 each  register-write enables for those stages.
REQ-011 stall_pc, stall_ifid, stall_dec  out  1 each  hold PC, IF/ID and ID/EX.
REQ-012 flush_ifid, flush  out  1 each  bubble IF/ID; bubble ID/EX (drives the ID/EX flush input).
REQ-013 fwd1_sel, fwd2_sel  out  fwd_sel_t (2)  ALU operand source: FWD_RF, FWD_EXM, FWD_WB.
REQ-014 mem_timeout  out  1  sticky error flag.
REQ-015 stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-016 FSM states HZ_RUN, HZ_REDIRECT, HZ_MEM_WAIT; stall/flush outputs combinational from state and inputs.
REQ-017 Priority within a cycle: mem_busy > branch_taken > load-use.
REQ-018 Load-use = DEC_out.Rmem & DEC_out.rd!=0 & ((id_use1 & DEC_out.rd==id_addr1) | (id_use2 & DEC_out.rd==id_addr2)).
REQ-019 HZ_RUN, load-use, no branch, no mem_busy: stall_pc=1, stall_ifid=1, flush=1 for exactly that cycle; state stays HZ_RUN.
REQ-020 HZ_RUN, branch_taken, no mem_busy: flush_ifid=1, flush=1, stall outputs 0; next state HZ_REDIRECT.
REQ-021 HZ_REDIRECT: flush_ifid=1 one further cycle (synchronous instruction memory latency), flush=0; returns to HZ_RUN unless mem_busy.
REQ-022 mem_busy in any state: stall_pc=stall_ifid=stall_dec=1, flush=flush_ifid=0; next state HZ_MEM_WAIT.
REQ-023 HZ_MEM_WAIT: stalls held while mem_busy=1; branch_taken seen here sets pending flag, flag applied as REQ-020 on first cycle with mem_busy=0.
REQ-024 HZ_MEM_WAIT exit with no pending flag: stalls drop same cycle mem_busy=0; next HZ_RUN.
REQ-025 8-bit wait counter cleared on entry to HZ_MEM_WAIT, increments each busy cycle, saturates; reaching MEM_TIMEOUT sets mem_timeout, held until reset.
REQ-026 Forwarding per operand n: FWD_EXM if exm_Wreg & exm_rd!=0 & exm_rd==DEC_out.addrn; else FWD_WB if same on wb_*; else FWD_RF. EX/MEM wins over MEM/WB.
REQ-027 x0 never forwarded, never triggers load-use.

Reset
REQ-028 nReset low: state HZ_RUN, pending flag 0, wait counter 0, mem_timeout 0, counters 0; all stall/flush outputs 0 while low.
REQ-029 Reset mid-HZ_MEM_WAIT or mid-HZ_REDIRECT discards pending flush and counter immediately.

Configuration
REQ-030 With HAZARD_PERF_EN defined: stall_cnt increments every cycle stall_pc=1; flush_cnt increments every cycle flush=1; both wrap at 2^32.
REQ-031 Without HAZARD_PERF_EN: counter logic absent; stall_cnt, flush_cnt tied to 0; all other behaviour identical.

Structure
REQ-032 hz_state_t and fwd_sel_t enums live in core_types_pkg; DEC_out_t taken from it unchanged.
REQ-033 Forwarding compare in sub-module hazard_fwd, instantiated once per operand.

Verification
REQ-034 DEC_out.Rmem=1, rd=5; id_addr1=5, id_use1=1 -> one cycle stall_pc=stall_ifid=flush=1, next cycle all 0.
REQ-035 branch_taken pulse 1 cycle -> flush=1 cycle N only; flush_ifid=1 cycles N and N+1.
REQ-036 mem_busy high 4 cycles with branch_taken in 2nd -> stalls 4 cycles, then flush=1, flush_ifid=1 for 2 cycles.
REQ-037 exm_rd=wb_rd=7, both Wreg=1, DEC_out.addr1=7 -> fwd1_sel=FWD_EXM; addr2=0 with wb_rd=0 -> fwd2_sel=FWD_RF.
REQ-038 MEM_TIMEOUT=3, mem_busy held 5 cycles -> mem_timeout rises after 3rd busy cycle, stays 1 after mem_busy falls; nReset clears it.
REQ-039 HAZARD_PERF_EN, 3 load-use events + 2 branches -> stall_cnt=3, flush_cnt=5.
